// File: rtl/uart_echo_ctrl.sv
// Echo controller between uart_core RX and TX: byte FIFO with optional line
// buffering (flush on CR or full), optional upcasing, and drop/level status.
module uart_echo_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LINE_MODE = 0,
  parameter int unsigned UPCASE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [15:0]              cfg_div,
  output logic                     cfg_txen,
  output logic                     cfg_rxen,
  output logic                     cfg_nstop,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned DIV = (CLK_FREQ / BAUD) - 1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  state_e        state_q, state_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    wdata;

  assign cfg_div    = 16'(DIV);
  assign cfg_txen   = 1'b1;
  assign cfg_rxen   = 1'b1;
  assign cfg_nstop  = 1'b0;
  assign drop_cnt   = drop_q;
  assign fifo_level = level_q;
  assign tx_data    = mem_q[rd_ptr_q];

  // Write/pop decisions, pointer and level bookkeeping, line-mode FSM.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    wdata    = rx_data;

    full = (level_q == LW'(DEPTH));
    push = rx_valid && !full;

    if (UPCASE != 0 && rx_data >= 8'h61 && rx_data <= 8'h7A) begin
      wdata = rx_data - 8'h20;
    end

    if (LINE_MODE != 0) begin
      tx_valid = (state_q == DRAIN) && (level_q != '0);
    end else begin
      tx_valid = (level_q != '0);
    end
    pop = tx_valid && tx_ready;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    // Full-FIFO writes are discarded even when a pop frees space this cycle.
    if (rx_valid && full && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      FILL: begin
        if (push && (rx_data == 8'h0D || level_q == LW'(DEPTH - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_d == '0) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      state_q  <= FILL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: three configurations share one stimulus stream and
// are each checked every cycle against a queue-based model.
module tb_uart_echo_ctrl;

  localparam int NDUT = 3;
  localparam int MDEP  [NDUT] = '{16, 4, 4};
  localparam int MLINE [NDUT] = '{0, 0, 1};
  localparam int MUP   [NDUT] = '{0, 1, 0};

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;

  logic [NDUT-1:0] tv;
  logic [7:0]      td [NDUT];
  logic [15:0]     cd [NDUT];
  logic [NDUT-1:0] ctx, crx, cns;
  logic [7:0]      dc [NDUT];
  logic [4:0]      lvl0;
  logic [2:0]      lvl1, lvl2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [NDUT][$];
  int         mdrop  [NDUT];
  bit         mdrain [NDUT];

  uart_echo_ctrl #(.DEPTH(16), .LINE_MODE(0), .UPCASE(0)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tv[0]), .tx_data(td[0]), .tx_ready(tx_ready),
    .cfg_div(cd[0]), .cfg_txen(ctx[0]), .cfg_rxen(crx[0]), .cfg_nstop(cns[0]),
    .drop_cnt(dc[0]), .fifo_level(lvl0));

  uart_echo_ctrl #(.DEPTH(4), .LINE_MODE(0), .UPCASE(1)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tv[1]), .tx_data(td[1]), .tx_ready(tx_ready),
    .cfg_div(cd[1]), .cfg_txen(ctx[1]), .cfg_rxen(crx[1]), .cfg_nstop(cns[1]),
    .drop_cnt(dc[1]), .fifo_level(lvl1));

  uart_echo_ctrl #(.DEPTH(4), .LINE_MODE(1), .UPCASE(0)) dut2 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tv[2]), .tx_data(td[2]), .tx_ready(tx_ready),
    .cfg_div(cd[2]), .cfg_txen(ctx[2]), .cfg_rxen(crx[2]), .cfg_nstop(cns[2]),
    .drop_cnt(dc[2]), .fifo_level(lvl2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_level(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  function automatic bit m_valid(input int k);
    return (MLINE[k] == 0 || mdrain[k]) && mq[k].size() != 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NDUT; k++) begin
      mq[k].delete();
      mdrop[k]  = 0;
      mdrain[k] = 1'b0;
    end
  endtask

  // Reference behaviour at a rising edge, from the current inputs.
  task automatic m_edge(input bit v, input logic [7:0] d, input bit r);
    for (int k = 0; k < NDUT; k++) begin
      int         sz;
      bit         pop, wr;
      logic [7:0] b;
      sz  = mq[k].size();
      pop = m_valid(k) && r;
      wr  = v && (sz < MDEP[k]);
      b   = (MUP[k] != 0 && d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
      if (v && !wr && mdrop[k] < 255) mdrop[k]++;
      if (pop) void'(mq[k].pop_front());
      if (wr) mq[k].push_back(b);
      if (MLINE[k] != 0) begin
        if (!mdrain[k]) begin
          if (wr && (d == 8'h0D || sz + 1 == MDEP[k])) mdrain[k] = 1'b1;
        end else if (mq[k].size() == 0) begin
          mdrain[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("valid%0d", k), int'(tv[k]), int'(m_valid(k)));
      if (m_valid(k)) chk($sformatf("data%0d", k), int'(td[k]), int'(mq[k][0]));
      chk($sformatf("level%0d", k), dut_level(k), mq[k].size());
      chk($sformatf("drop%0d", k), int'(dc[k]), mdrop[k]);
    end
  endtask

  // One clock: drive at edge+1, compare at negedge, update model at edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r);
    rx_valid = v;
    rx_data  = d;
    tx_ready = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    m_edge(v, d, r);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, r);
  endtask

  task automatic chk_cfg();
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("cfg_div%0d", k), int'(cd[k]), 433);
      chk($sformatf("cfg_en%0d", k), int'({ctx[k], crx[k], cns[k]}), 3'b110);
    end
  endtask

  initial begin
    logic [7:0] seq [4];
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    m_reset();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", int'(tv), 0);
    chk("rst_level", dut_level(0) + dut_level(1) + dut_level(2), 0);
    chk("rst_drop", int'(dc[0]) + int'(dc[1]) + int'(dc[2]), 0);
    chk_cfg();
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte echo: hold three bytes, then stream them out back to back.
    cyc(1'b1, 8'h41, 1'b0); cyc(1'b1, 8'h62, 1'b0); cyc(1'b1, 8'h0D, 1'b0);
    idle(20, 1'b0);
    chk("echo_level", dut_level(0), 3);
    idle(6, 1'b1);
    chk("echo_empty", dut_level(0), 0);

    // Upcase conversion including range edges.
    seq = '{8'h61, 8'h7A, 8'h7B, 8'h40};
    foreach (seq[i]) cyc(1'b1, seq[i], 1'b1);
    idle(6, 1'b1);

    // Line mode holds until CR, then releases on the next cycle.
    cyc(1'b1, 8'h68, 1'b1); cyc(1'b1, 8'h69, 1'b1);
    idle(3, 1'b1);
    chk("line_hold", int'(tv[2]), 0);
    cyc(1'b1, 8'h0D, 1'b1);
    @(negedge clk);
    chk("line_release", int'(tv[2]), 1);
    @(posedge clk); #1;
    rst = 1'b1; #1; rst = 1'b0; m_reset();
    cyc(1'b1, 8'h68, 1'b1); cyc(1'b1, 8'h69, 1'b1); cyc(1'b1, 8'h0D, 1'b1);
    idle(6, 1'b1);
    chk("line_back_fill", int'(tv[2]), 0);

    // Overflow on the four-deep instances.
    for (int i = 1; i <= 7; i++) cyc(1'b1, 8'(i), 1'b0);
    idle(1, 1'b0);
    chk("ovf_level", dut_level(1), 4);
    chk("ovf_drop", int'(dc[1]), 3);
    idle(8, 1'b1);

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    idle(1, 1'b0);
    chk("sat_drop1", int'(dc[1]), 255);
    chk("sat_drop0", int'(dc[0]), 255);
    idle(20, 1'b1);

    // Line-mode full flush without CR, repeated so pointers wrap.
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + b * 4 + i), 1'b1);
      idle(6, 1'b1);
    end

    // Simultaneous push and pop at level 2.
    cyc(1'b1, 8'h11, 1'b0); cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b1);
    idle(1, 1'b0);
    chk("simul_level", dut_level(0), 2);
    idle(8, 1'b1);

    // Randomised traffic with varying back-pressure.
    for (int s = 0; s < 4; s++) begin
      int rp;
      rp = (s == 0) ? 20 : (s == 1) ? 50 : (s == 2) ? 80 : 95;
      for (int i = 0; i < 500; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
        cyc($urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < rp);
      end
    end
    idle(30, 1'b1);

    // Reset mid-drain clears outputs without waiting for a clock.
    cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h0D, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", int'(tv[2]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(tv), 0);
    chk("rst_async_level", dut_level(0) + dut_level(1) + dut_level(2), 0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4, 1'b1);
    chk_cfg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Parametrised echo controller between the RX and TX streams of `uart_core`. It replaces direct RX-to-TX loopback wiring with a DEPTH-entry byte FIFO, so back-to-back RX bytes are not lost while TX is busy. It adds a line-buffered echo mode, optional lowercase-to-uppercase conversion, and drop/level status. It also drives the static `cfg_*` inputs of `uart_core`, which it derives from clock and baud parameters.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: baud rate.
- DEPTH, 16: FIFO entries; power of 2, ≥ 2.
- LINE_MODE, 0: 0 = byte echo; 1 = buffer until CR (0x0D) or FIFO full, then flush.
- UPCASE, 0: 1 = convert 0x61–0x7A to 0x41–0x5A on write.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- rx_data  in  8  received byte.
- tx_valid  out  1  a byte is offered to uart_core TX.
- tx_data  out  8  byte offered; stable while tx_valid && !tx_ready.
- tx_ready  in  1  TX accepts; a transfer occurs when tx_valid && tx_ready.
- cfg_div  out  16  constant CLK_FREQ/BAUD − 1, integer division (433 for the defaults).
- cfg_txen, cfg_rxen  out  1  constant 1.
- cfg_nstop  out  1  constant 0 (one stop bit).
- drop_cnt  out  8  count of dropped RX bytes; saturates at 255.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- **FIFO storage**
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits; both wrap DEPTH−1 → 0.
  - Occupancy is held in a separate level register.
- **Write path**
  - On rx_valid with level < DEPTH (evaluated before any same-cycle pop), the transformed byte is stored.
  - Transform: if UPCASE=1 and 0x61 ≤ byte ≤ 0x7A, store byte − 0x20; otherwise store the byte unchanged.
- **Drop**
  - On rx_valid with level == DEPTH, the byte is discarded, even if a pop occurs in the same cycle.
  - drop_cnt increments by 1, saturating at 255.
- **Pop**
  - Occurs when tx_valid && tx_ready; rd_ptr then advances.
  - tx_data = mem[rd_ptr], read combinationally from registered storage.
- **Simultaneous push and pop** (level not full): level is unchanged and both pointers advance.
- **Byte mode (LINE_MODE=0)**: tx_valid = (level != 0).
- **Line mode (LINE_MODE=1)**: two-state FSM.
  - FILL: tx_valid = 0. Go to DRAIN after a cycle in which the accepted write's *original* byte is 0x0D, or in which the write makes level == DEPTH.
  - DRAIN: tx_valid = (level != 0). Go to FILL when the next level is 0, i.e. a pop empties the FIFO with no same-cycle write.
  - Writes continue to be accepted during DRAIN and are flushed in the same burst.
  - Drops in FILL cannot occur, because the FIFO reaching full forces DRAIN.
- **Reset**
  - Reset asserted at any time aborts operation: pointers, level, FSM, and counters clear immediately.
  - FIFO contents are not cleared but are unreachable.
  - A pending tx_valid drops asynchronously; the byte is lost.

## Timing
- Reset values:
  - tx_valid = 0, drop_cnt = 0, fifo_level = 0.
  - FSM = FILL.
  - tx_data = don't-care.
  - cfg_* outputs are constant.
- Byte-mode latency: rx_valid in cycle N gives tx_valid = 1 in cycle N+1, with tx_data equal to that byte when the FIFO was empty.
- Line-mode latency: CR written in cycle N gives DRAIN and tx_valid = 1 in cycle N+1.
- fifo_level updates one cycle after the push or pop event.
- drop_cnt updates one cycle after the dropping rx_valid.
- Throughput: one pop per cycle whenever tx_ready is held high.
- tx_data changes only after a pop or, from the empty state, after a write.

## Test plan
- **Byte echo:**
  - Stimulus: LINE_MODE=0; send 0x41, 0x62, 0x0D one cycle apart, with tx_ready = 0 for 20 cycles.
  - Response: fifo_level reaches 3.
  - Then raise tx_ready: tx emits 0x41, 0x62, 0x0D on three consecutive cycles, and level returns to 0.
- **Upcase:**
  - Stimulus: UPCASE=1; send 0x61, 0x7A, 0x7B, 0x40.
  - Response: tx emits 0x41, 0x5A, 0x7B, 0x40.
- **Overflow:**
  - Stimulus: DEPTH=4, tx_ready = 0; send 7 bytes 0x01..0x07.
  - Response: level = 4 and drop_cnt = 3; then tx emits 0x01..0x04 only.
  - Saturation: send 300 bytes while full; drop_cnt = 255.
- **Line mode:**
  - Stimulus: send 0x68, 0x69 with tx_ready = 1.
  - Response: tx_valid stays 0.
  - Stimulus: send 0x0D.
  - Response: cycle after the CR, tx_valid = 1; emits 0x68, 0x69, 0x0D; FSM returns to FILL; tx_valid = 0.
- **Line-mode full flush and wrap:**
  - Stimulus: DEPTH=4; 4 non-CR bytes.
  - Response: DRAIN entered without a CR.
  - Run 10 such bursts so the pointers wrap; data order is preserved each time.
- **Simultaneous events and reset:**
  - Stimulus: at level 2, assert rx_valid and a pop in the same cycle.
  - Response: level stays 2.
  - Stimulus: assert rst mid-drain.
  - Response: tx_valid = 0 and fifo_level = 0 immediately; cfg_div = 433 throughout.
